i2c_master_wr: RTL

//  Single-register I2C write master. Consumes the divided i2c_clk and turns each

---
 rtl/i2c_master_wr.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/i2c_master_wr.sv
// Single-register I2C write master: START, {dev_addr,W}, reg_addr, wr_data, STOP.
// Every edge of the divided i2c_clk is one quarter-bit tick; SCL/SDA are open-drain enables.
module i2c_master_wr #(
  parameter bit STOP_ON_NACK = 1'b1
) (
  input  logic       ref_clk,
  input  logic       rst,
  input  logic       i2c_clk,
  input  logic       start,
  input  logic [6:0] dev_addr,
  input  logic [7:0] reg_addr,
  input  logic [7:0] wr_data,
  input  logic       sda_in,
  output logic       scl_oe,
  output logic       sda_oe,
  output logic       busy,
  output logic       done,
  output logic       ack_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_SEND,
    S_ACK,
    S_STOP,
    S_DONE
  } state_t;

  state_t     state, state_d;
  logic [1:0] phase, phase_d;
  logic [2:0] bit_idx, bit_idx_d;
  logic [1:0] byte_idx, byte_idx_d;

  logic [6:0] dev_q;
  logic [7:0] reg_q;
  logic [7:0] data_q;
  logic [7:0] cur_byte;
  logic       cur_bit;

  logic i2c_clk_q;
  logic tick;
  logic scl_oe_d, sda_oe_d, busy_d, done_d, ack_err_d;

  always_ff @(posedge ref_clk) begin
    i2c_clk_q <= i2c_clk;
  end

  assign tick = i2c_clk ^ i2c_clk_q;

  // NOTE: the request fields are plain data captured on accept; nothing reads them
  // before the first accept, so they carry no reset and stay a simple enabled register.
  always_ff @(posedge ref_clk) begin
    if (state == S_IDLE && start) begin
      dev_q  <= dev_addr;
      reg_q  <= reg_addr;
      data_q <= wr_data;
    end
  end

  always_comb begin
    case (byte_idx)
      2'd0:    cur_byte = {dev_q, 1'b0};
      2'd1:    cur_byte = reg_q;
      default: cur_byte = data_q;
    endcase
  end

  assign cur_bit = cur_byte[bit_idx];

  // State register; the outputs are registered alongside it.
  // NOTE: every flop here uses <= so all of them sample the pre-edge values of the
  // others; a blocking = would let later statements see half-updated state.
  always_ff @(posedge ref_clk) begin
    if (rst) begin
      state    <= S_IDLE;
      phase    <= 2'd0;
      bit_idx  <= 3'd0;
      byte_idx <= 2'd0;
      scl_oe   <= 1'b0;
      sda_oe   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      ack_err  <= 1'b0;
    end else begin
      state    <= state_d;
      phase    <= phase_d;
      bit_idx  <= bit_idx_d;
      byte_idx <= byte_idx_d;
      scl_oe   <= scl_oe_d;
      sda_oe   <= sda_oe_d;
      busy     <= busy_d;
      done     <= done_d;
      ack_err  <= ack_err_d;
    end
  end

  // Next-state logic. Only IDLE accept and DONE move without a tick.
  // NOTE: each variable gets its hold value before the case, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_d    = state;
    phase_d    = phase;
    bit_idx_d  = bit_idx;
    byte_idx_d = byte_idx;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_d = S_START;
          phase_d = 2'd0;
        end
      end
      S_START: begin
        if (tick) begin
          if (phase == 2'd0) begin
            phase_d = 2'd1;
          end else begin
            state_d    = S_SEND;
            phase_d    = 2'd0;
            byte_idx_d = 2'd0;
            bit_idx_d  = 3'd7;
          end
        end
      end
      S_SEND: begin
        if (tick) begin
          phase_d = phase + 2'd1;
          if (phase == 2'd3) begin
            phase_d = 2'd0;
            if (bit_idx == 3'd0) state_d = S_ACK;
            else                 bit_idx_d = bit_idx - 3'd1;
          end
        end
      end
      S_ACK: begin
        if (tick) begin
          phase_d = phase + 2'd1;
          if (phase == 2'd3) begin
            phase_d = 2'd0;
            // ack_err is sticky, but with abort enabled the first NACK already ends the frame
            if (ack_err && STOP_ON_NACK) begin
              state_d = S_STOP;
            end else if (byte_idx < 2'd2) begin
              byte_idx_d = byte_idx + 2'd1;
              bit_idx_d  = 3'd7;
              state_d    = S_SEND;
            end else begin
              state_d = S_STOP;
            end
          end
        end
      end
      S_STOP: begin
        if (tick) begin
          phase_d = phase + 2'd1;
          if (phase == 2'd3) begin
            phase_d = 2'd0;
            state_d = S_DONE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic: next values for the registered line enables and status flags.
  always_comb begin
    scl_oe_d  = scl_oe;
    sda_oe_d  = sda_oe;
    busy_d    = busy;
    done_d    = 1'b0;
    ack_err_d = ack_err;
    case (state)
      S_IDLE: begin
        if (start) begin
          busy_d    = 1'b1;
          ack_err_d = 1'b0;
        end
      end
      S_START: begin
        if (tick) begin
          if (phase == 2'd0) sda_oe_d = 1'b1;
          else               scl_oe_d = 1'b1;
        end
      end
      S_SEND, S_ACK: begin
        if (tick) begin
          case (phase)
            2'd0:    sda_oe_d = (state == S_SEND) ? ~cur_bit : 1'b0;
            2'd1:    scl_oe_d = 1'b0;
            2'd2:    if (state == S_ACK && sda_in) ack_err_d = 1'b1;
            default: scl_oe_d = 1'b1;
          endcase
        end
      end
      S_STOP: begin
        if (tick) begin
          case (phase)
            2'd0:    sda_oe_d = 1'b1;
            2'd1:    scl_oe_d = 1'b0;
            2'd2:    sda_oe_d = 1'b0;
            default: begin end
          endcase
        end
      end
      S_DONE: begin
        done_d = 1'b1;
        busy_d = 1'b0;
      end
      default: begin end
    endcase
  end

endmodule
